unified_mem_arbiter: RTL and testbench

//   Shares one single-port memory between the pipeline's instruction-fetch port and data port.

---
 rtl/unified_mem_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between the instruction-fetch port and the data port.
// One outstanding transaction at a time; data wins over fetch except when fetch has starved.
module unified_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        reset,
    // fetch port
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    // data port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        bus_err,
    // memory port
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    // performance
    output logic [31:0] conflict_cnt
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic           own_data_q, own_data_d;
    logic           we_q, we_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [3:0]     wstrb_q, wstrb_d;
    logic           mem_req_q, mem_req_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic [31:0]    conflict_q, conflict_d;
    logic           if_valid_q, if_valid_d;
    logic           d_valid_q, d_valid_d;
    logic           bus_err_q, bus_err_d;
    logic [31:0]    if_rdata_q, if_rdata_d;
    logic [31:0]    d_rdata_q, d_rdata_d;

    logic           data_wins_s;
    logic           fetch_wins_s;
    logic [TW-1:0]  timer_inc_s;
    logic [31:0]    rsp_data_s;

    // Fetch only overrides a pending data request once it has lost STARVE_LIMIT times in a row
    assign data_wins_s  = d_req && !(if_req && (starve_q == STARVE_MAX));
    assign fetch_wins_s = if_req && !data_wins_s;
    assign timer_inc_s  = timer_q + TW'(1);
    assign rsp_data_s   = we_q ? 32'h0000_0000 : mem_rdata;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            own_data_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            wstrb_q    <= 4'b0000;
            mem_req_q  <= 1'b0;
            timer_q    <= '0;
            starve_q   <= '0;
            conflict_q <= 32'h0000_0000;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            if_rdata_q <= 32'h0000_0000;
            d_rdata_q  <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            own_data_q <= own_data_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            mem_req_q  <= mem_req_d;
            timer_q    <= timer_d;
            starve_q   <= starve_d;
            conflict_q <= conflict_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            bus_err_q  <= bus_err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Arbitration, transaction sequencing and completion reporting
    always_comb begin
        state_d    = state_q;
        own_data_d = own_data_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        mem_req_d  = mem_req_q;
        timer_d    = timer_q;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        bus_err_d  = 1'b0;
        if_rdata_d = 32'h0000_0000;
        d_rdata_d  = 32'h0000_0000;

        case (state_q)
            S_IDLE: begin
                if (data_wins_s) begin
                    state_d    = S_REQ;
                    own_data_d = 1'b1;
                    we_d       = d_we;
                    addr_d     = d_addr;
                    wdata_d    = d_wdata;
                    wstrb_d    = d_we ? d_wstrb : 4'b0000;
                    mem_req_d  = 1'b1;
                end else if (fetch_wins_s) begin
                    state_d    = S_REQ;
                    own_data_d = 1'b0;
                    we_d       = 1'b0;
                    addr_d     = if_addr;
                    wdata_d    = 32'h0000_0000;
                    wstrb_d    = 4'b0000;
                    mem_req_d  = 1'b1;
                end else begin
                    state_d    = S_IDLE;
                    mem_req_d  = 1'b0;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    state_d   = S_WAIT;
                    mem_req_d = 1'b0;
                    timer_d   = '0;
                end else begin
                    state_d   = S_REQ;
                    mem_req_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_d = S_IDLE;
                    if (own_data_q) begin
                        d_valid_d = 1'b1;
                        d_rdata_d = rsp_data_s;
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = rsp_data_s;
                    end
                end else if (timer_inc_s == TIMER_LAST) begin
                    // Abort lands the error pulse exactly TIMEOUT cycles after the grant
                    state_d   = S_IDLE;
                    bus_err_d = 1'b1;
                    if (own_data_q) begin
                        d_valid_d = 1'b1;
                    end else begin
                        if_valid_d = 1'b1;
                    end
                end else begin
                    state_d = S_WAIT;
                    timer_d = timer_inc_s;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Starvation counter for the fetch port
    always_comb begin
        starve_d = starve_q;
        if (!if_req) begin
            starve_d = '0;
        end else if ((state_q == S_IDLE) && fetch_wins_s) begin
            starve_d = '0;
        end else if ((state_q == S_IDLE) && data_wins_s && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Contention counter: idle cycles with both ports requesting
    always_comb begin
        conflict_d = conflict_q;
        if ((state_q == S_IDLE) && if_req && d_req) begin
            conflict_d = conflict_q + 32'd1;
        end else begin
            conflict_d = conflict_q;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_wstrb    = wstrb_q;
    assign if_valid     = if_valid_q;
    assign if_rdata     = if_rdata_q;
    assign d_valid      = d_valid_q;
    assign d_rdata      = d_rdata_q;
    assign bus_err      = bus_err_q;
    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Testbench for unified_mem_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_unified_mem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we, mem_gnt, mem_rvalid;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_wstrb;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, conflict_cnt;
    logic        if_valid, d_valid, bus_err, mem_req, mem_we;
    logic [3:0]  mem_wstrb;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_valid(d_valid), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .conflict_cnt(conflict_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // stimulus knobs
    bit rand_req = 1'b0;
    bit stray    = 1'b0;
    int gnt_pct  = 100;
    int rv_pct   = 100;
    int req_pct  = 60;

    // reference model: one pending transaction, judged by cycle numbers
    bit          m_busy, m_granted, m_own_d, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    int          m_starve, m_deadline;
    logic [31:0] m_conf;
    bit          e_if_valid, e_d_valid, e_err;
    logic [31:0] e_if_rdata, e_d_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got '%s', expected '%s'", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_granted = 1'b0; m_own_d = 1'b0; m_we = 1'b0;
        m_addr = 32'h0; m_wdata = 32'h0; m_wstrb = 4'h0;
        m_starve = 0; m_deadline = 0; m_conf = 32'h0;
        e_if_valid = 1'b0; e_d_valid = 1'b0; e_err = 1'b0;
        e_if_rdata = 32'h0; e_d_rdata = 32'h0;
    endtask

    task automatic model_finish(input bit err, input logic [31:0] data);
        if (m_own_d) begin e_d_valid = 1'b1; e_d_rdata = data; end
        else begin e_if_valid = 1'b1; e_if_rdata = data; end
        e_err  = err;
        m_busy = 1'b0;
    endtask

    // advance the model over the cycle numbered 'now', which ends at this edge
    task automatic model_step(input int now);
        bit take_d;
        e_if_valid = 1'b0; e_d_valid = 1'b0; e_err = 1'b0;
        if (!m_busy) begin
            if (if_req && d_req) m_conf = m_conf + 32'd1;
            take_d = d_req && !(if_req && m_starve >= STARVE_LIMIT);
            if (take_d) begin
                m_busy = 1'b1; m_granted = 1'b0; m_own_d = 1'b1; m_we = d_we;
                m_addr = d_addr; m_wdata = d_wdata; m_wstrb = d_we ? d_wstrb : 4'h0;
                m_starve = if_req ? ((m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1) : 0;
            end else if (if_req) begin
                m_busy = 1'b1; m_granted = 1'b0; m_own_d = 1'b0; m_we = 1'b0;
                m_addr = if_addr; m_wdata = 32'h0; m_wstrb = 4'h0;
                m_starve = 0;
            end else begin
                m_starve = 0;
            end
        end else begin
            if (!if_req) m_starve = 0;
            if (!m_granted) begin
                if (mem_gnt) begin m_granted = 1'b1; m_deadline = now + TIMEOUT; end
            end else if (mem_rvalid) begin
                model_finish(1'b0, m_we ? 32'h0 : mem_rdata);
            end else if (now + 1 == m_deadline) begin
                model_finish(1'b1, 32'h0);
            end
        end
    endtask

    task automatic compare_outputs();
        chk("if_valid", if_valid, e_if_valid);
        chk("d_valid", d_valid, e_d_valid);
        chk("bus_err", bus_err, e_err);
        if (e_if_valid) chk("if_rdata", if_rdata, e_if_rdata);
        if (e_d_valid)  chk("d_rdata", d_rdata, e_d_rdata);
        chk("mem_req", mem_req, m_busy && !m_granted);
        if (m_busy && !m_granted) begin
            chk("mem_we", mem_we, m_we);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("mem_wstrb", mem_wstrb, m_wstrb);
        end
        chk("conflict_cnt", conflict_cnt, m_conf);
        if (reset) begin
            chk("rst_mem_addr", mem_addr, 32'h0);
            chk("rst_mem_wstrb", mem_wstrb, 4'h0);
            chk("rst_mem_we", mem_we, 1'b0);
            chk("rst_d_rdata", d_rdata, 32'h0);
            chk("rst_if_rdata", if_rdata, 32'h0);
        end
    endtask

    // model update at each edge, DUT comparison just after it
    always @(posedge clk) begin
        if (reset) model_reset();
        else model_step(cyc);
        cyc = cyc + 1;
        #1;
        compare_outputs();
    end

    task automatic drive_mem();
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
        if (m_busy && !m_granted) mem_gnt = ($urandom_range(0, 99) < gnt_pct);
        else if (stray && $urandom_range(0, 7) == 0) mem_gnt = 1'b1;
        if (m_busy && m_granted) mem_rvalid = ($urandom_range(0, 99) < rv_pct);
        else if (stray && $urandom_range(0, 7) == 0) mem_rvalid = 1'b1;
    endtask

    task automatic drive_reqs();
        if (if_req) begin
            if (e_if_valid) begin
                if ($urandom_range(0, 1) == 1) if_addr = $urandom;
                else if_req = 1'b0;
            end
        end else if ($urandom_range(0, 99) < req_pct) begin
            if_req = 1'b1; if_addr = $urandom;
        end
        if (d_req) begin
            if (e_d_valid) begin
                if ($urandom_range(0, 1) == 1) begin
                    d_we = $urandom_range(0, 1); d_addr = $urandom; d_wdata = $urandom; d_wstrb = $urandom;
                end else d_req = 1'b0;
            end
        end else if ($urandom_range(0, 99) < req_pct) begin
            d_req = 1'b1; d_we = $urandom_range(0, 1); d_addr = $urandom;
            d_wdata = $urandom; d_wstrb = $urandom;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        drive_mem();
        if (rand_req) drive_reqs();
    endtask

    task automatic do_reset();
        rand_req = 1'b0; stray = 1'b0;
        reset = 1'b1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
        tick(); tick();
        reset = 1'b0;
    endtask

    initial begin
        string seq;
        int    g, vc;
        bit    found;
        reset = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
        tick(); tick();
        chk("reset_mem_req", mem_req, 1'b0);
        chk("reset_conflict", conflict_cnt, 32'h0);
        reset = 1'b0;

        // fetch only, minimum latency
        do_reset();
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        chk("t1_mem_req", mem_req, 1'b1);
        chk("t1_mem_addr", mem_addr, 32'h100);
        chk("t1_mem_wstrb", mem_wstrb, 4'b0000);
        tick();
        mem_rdata = 32'h0050_0093;
        chk("t1_mem_req_low", mem_req, 1'b0);
        tick();
        chk("t1_if_valid", if_valid, 1'b1);
        chk("t1_if_rdata", if_rdata, 32'h0050_0093);
        chk("t1_d_valid", d_valid, 1'b0);
        if_req = 1'b0;
        tick();
        chk("t1_if_valid_pulse", if_valid, 1'b0);

        // simultaneous fetch + data load: data first
        do_reset();
        if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        tick();
        chk("t2_first_addr", mem_addr, 32'h2000);
        chk("t2_conflict", conflict_cnt, 32'd1);
        tick(); tick();
        chk("t2_d_valid", d_valid, 1'b1);
        chk("t2_if_valid", if_valid, 1'b0);
        d_req = 1'b0;
        tick();
        chk("t2_second_addr", mem_addr, 32'h200);
        chk("t2_conflict_after", conflict_cnt, 32'd1);
        tick(); tick();
        chk("t2_if_valid_late", if_valid, 1'b1);
        if_req = 1'b0;

        // store held until grant
        do_reset();
        gnt_pct = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_mem_req", mem_req, 1'b1);
            chk("t3_mem_we", mem_we, 1'b1);
            chk("t3_mem_wstrb", mem_wstrb, 4'b0011);
            chk("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        end
        mem_gnt = 1'b1;
        gnt_pct = 100;
        tick();
        mem_rdata = 32'h1234_5678;
        tick();
        chk("t3_d_valid", d_valid, 1'b1);
        chk("t3_d_rdata", d_rdata, 32'h0);
        d_req = 1'b0;

        // starvation guard with both ports requesting continuously
        do_reset();
        seq = "";
        if_req = 1'b1; if_addr = 32'h1000; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (d_valid === 1'b1) seq = {seq, "D"};
            if (if_valid === 1'b1) seq = {seq, "F"};
        end
        chk_str("t4_order", seq.substr(0, 5), "DDDDFD");

        // timeout: rvalid withheld
        do_reset();
        rv_pct = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        tick();
        g = cyc;
        found = 1'b0; vc = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (d_valid === 1'b1) begin
                found = 1'b1; vc = cyc;
                chk("t5_bus_err", bus_err, 1'b1);
                chk("t5_d_rdata", d_rdata, 32'h0);
                d_req = 1'b0;
            end
        end
        chk("t5_found", found, 1'b1);
        chk("t5_latency", vc - g, 32'd64);
        rv_pct = 100;
        if_req = 1'b1; if_addr = 32'h300;
        tick(); tick(); tick();
        chk("t5_next_valid", if_valid, 1'b1);
        chk("t5_next_err", bus_err, 1'b0);
        if_req = 1'b0;

        // reset while requesting drops mem_req at once
        do_reset();
        gnt_pct = 0;
        d_req = 1'b1; d_addr = 32'h44;
        tick();
        chk("t6_req_before", mem_req, 1'b1);
        reset = 1'b1; #1;
        chk("t6_req_drop", mem_req, 1'b0);
        d_req = 1'b0;
        tick();
        reset = 1'b0;
        gnt_pct = 100;

        // reset while waiting, then a late response
        do_reset();
        rv_pct = 0;
        d_req = 1'b1; d_addr = 32'h48;
        tick(); tick();
        reset = 1'b1; #1;
        chk("t6_wait_req", mem_req, 1'b0);
        chk("t6_wait_dvalid", d_valid, 1'b0);
        d_req = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0000;
            chk("t6_no_dvalid", d_valid, 1'b0);
            chk("t6_no_ifvalid", if_valid, 1'b0);
        end
        rv_pct = 100;

        // randomized traffic, then a slow-memory phase that provokes timeouts
        do_reset();
        rand_req = 1'b1; stray = 1'b1; gnt_pct = 50; rv_pct = 40; req_pct = 60;
        repeat (1500) tick();
        rv_pct = 3;
        repeat (700) tick();
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
